// File: rtl/ftdi_fifo_responder.sv
// ftdi_fifo_responder
//   Device-side stand-in for an FT232H in async-245 FIFO mode, used to loop an
//   FPGA-side FTDI master back onto itself (or onto a host adapter) on-chip.
//   The master strobes RD#/WR#; this block answers with RXF#/TXE# and the bus.
//   Valid/ready semantics on the host side: a transfer happens on a rising
//   clock edge where valid && ready are both high; valid may not depend on ready.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   ftdi_rd, ftdi_wr    RD#/WR# strobes from the master (active low, async)
//   adbus_in            byte from the master, valid while WR# is low
//   rxf, txe            RXF#/TXE# (active low, registered)
//   adbus_out, adbus_oe RX head byte (show-ahead) and bus drive enable (= ~RD#)
//   host_tx_*           host -> FPGA byte stream into the RX buffer
//   host_rx_*           FPGA -> host byte stream out of the TX buffer
//   rx_count, tx_count  buffer occupancies
//   err_proto           sticky strobe protocol error
//   dbg_state           FSM state: 0 IDLE, 1 RD_ACT, 2 WR_ACT, 3 RECOVER
module ftdi_fifo_responder #(
  parameter int RX_DEPTH       = 1024,
  parameter int TX_DEPTH       = 2048,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ftdi_rd,
  input  logic                      ftdi_wr,
  input  logic [7:0]                adbus_in,
  output logic                      rxf,
  output logic                      txe,
  output logic [7:0]                adbus_out,
  output logic                      adbus_oe,
  input  logic [7:0]                host_tx_data,
  input  logic                      host_tx_valid,
  output logic                      host_tx_ready,
  output logic [7:0]                host_rx_data,
  output logic                      host_rx_valid,
  input  logic                      host_rx_ready,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic [$clog2(TX_DEPTH):0] tx_count,
  output logic                      err_proto,
  output logic [1:0]                dbg_state
);

  localparam int RXA = $clog2(RX_DEPTH);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam logic [RXA:0] RX_FULL_CNT = (RXA + 1)'(RX_DEPTH);
  localparam logic [TXA:0] TX_FULL_CNT = (TXA + 1)'(TX_DEPTH);
  localparam logic [3:0]   REC_LOAD    = 4'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_ACT  = 2'd1,
    S_WR_ACT  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t r_state, w_state_next;

  // Input synchronisers and edge detection
  logic       r_rd_s1, r_rd_s2, r_rd_s3;
  logic       r_wr_s1, r_wr_s2, r_wr_s3;
  logic [7:0] r_ad_s1, r_ad_s2;
  logic       r_post_rst, r_rd_armed, r_wr_armed;
  logic       w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_s1 <= 1'b1; r_rd_s2 <= 1'b1; r_rd_s3 <= 1'b1;
      r_wr_s1 <= 1'b1; r_wr_s2 <= 1'b1; r_wr_s3 <= 1'b1;
      r_ad_s1 <= 8'h00; r_ad_s2 <= 8'h00;
      r_post_rst <= 1'b1;
      r_rd_armed <= 1'b0;
      r_wr_armed <= 1'b0;
    end else begin
      r_rd_s1 <= ftdi_rd; r_rd_s2 <= r_rd_s1; r_rd_s3 <= r_rd_s2;
      r_wr_s1 <= ftdi_wr; r_wr_s2 <= r_wr_s1; r_wr_s3 <= r_wr_s2;
      r_ad_s1 <= adbus_in; r_ad_s2 <= r_ad_s1;
      r_post_rst <= 1'b0;
      // A strobe counts only once it has been seen high after reset, so a
      // strobe still low at reset release does not fake a falling edge.
      // The first s1 sample after reset is the reset value, hence r_post_rst.
      r_rd_armed <= r_rd_armed | (r_rd_s1 & ~r_post_rst);
      r_wr_armed <= r_wr_armed | (r_wr_s1 & ~r_post_rst);
    end
  end

  assign w_rd_fall = r_rd_armed && !r_rd_s2 && r_rd_s3;
  assign w_rd_rise = r_rd_s2 && !r_rd_s3;
  assign w_wr_fall = r_wr_armed && !r_wr_s2 && r_wr_s3;
  assign w_wr_rise = r_wr_s2 && !r_wr_s3;

  // Buffers
  logic [7:0]     r_rx_mem [RX_DEPTH];
  logic [7:0]     r_tx_mem [TX_DEPTH];
  logic [RXA-1:0] r_rx_wptr, r_rx_rptr;
  logic [TXA-1:0] r_tx_wptr, r_tx_rptr;
  logic [RXA:0]   r_rx_count;
  logic [TXA:0]   r_tx_count;
  logic           w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic           w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic           w_err_set, w_rd_take;

  assign w_rx_empty = (r_rx_count == '0);
  assign w_rx_full  = (r_rx_count == RX_FULL_CNT);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_full  = (r_tx_count == TX_FULL_CNT);
  assign w_rx_push  = host_tx_valid && !w_rx_full;
  assign w_tx_pop   = host_rx_ready && !w_tx_empty;

  always_ff @(posedge clock) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= host_tx_data;
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= r_ad_s2;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_wptr <= '0; r_rx_rptr <= '0; r_rx_count <= '0;
      r_tx_wptr <= '0; r_tx_rptr <= '0; r_tx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + RXA'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RXA'(1);
      if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + (RXA + 1)'(1);
      else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - (RXA + 1)'(1);
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + TXA'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TXA'(1);
      if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + (TXA + 1)'(1);
      else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - (TXA + 1)'(1);
    end
  end

  // FSM: state register
  logic [3:0] r_rec_cnt;
  logic       r_rd_valid;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rd_fall)      w_state_next = S_RD_ACT;
        else if (w_wr_fall) w_state_next = S_WR_ACT;
      end
      S_RD_ACT:  if (w_rd_rise) w_state_next = S_RECOVER;
      S_WR_ACT:  if (w_wr_rise) w_state_next = S_RECOVER;
      S_RECOVER: if (r_rec_cnt == 4'd0) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs (buffer actions and error events)
  always_comb begin
    w_rx_pop  = 1'b0;
    w_tx_push = 1'b0;
    w_err_set = 1'b0;
    w_rd_take = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rd_fall) begin
          // Read wins a simultaneous fall; the write is discarded.
          w_rd_take = !w_rx_empty;
          if (w_rx_empty || w_wr_fall) w_err_set = 1'b1;
        end else if (w_wr_fall) begin
          if (w_tx_full) w_err_set = 1'b1;
          else           w_tx_push = 1'b1;
        end
      end
      S_RD_ACT: begin
        // Pop only a byte that was present when RD# fell, not one the host
        // pushed into an empty buffer while RD# was low.
        if (w_rd_rise && r_rd_valid) w_rx_pop = 1'b1;
        if (w_wr_fall) w_err_set = 1'b1;
      end
      S_WR_ACT: if (w_rd_fall) w_err_set = 1'b1;
      default: ;
    endcase
  end

  // Registered flags, recovery counter, sticky error
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rec_cnt  <= 4'd0;
      r_rd_valid <= 1'b0;
      err_proto  <= 1'b0;
      rxf        <= 1'b1;
      txe        <= 1'b1;
    end else begin
      if (w_state_next == S_RECOVER && r_state != S_RECOVER) r_rec_cnt <= REC_LOAD;
      else if (r_state == S_RECOVER && r_rec_cnt != 4'd0)    r_rec_cnt <= r_rec_cnt - 4'd1;
      if (r_state == S_IDLE && w_rd_fall) r_rd_valid <= w_rd_take;
      if (w_err_set) err_proto <= 1'b1;
      // Next state makes both flags go inactive the cycle after a fall.
      rxf <= ~(w_state_next == S_IDLE && !w_rx_empty);
      txe <= ~(w_state_next == S_IDLE && !w_tx_full);
    end
  end

  assign adbus_out     = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];
  assign adbus_oe      = ~ftdi_rd;
  assign host_tx_ready = ~w_rx_full;
  assign host_rx_data  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rptr];
  assign host_rx_valid = ~w_tx_empty;
  assign rx_count      = r_rx_count;
  assign tx_count      = r_tx_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_ftdi_fifo_responder.sv
// tb_ftdi_fifo_responder
//   Directed bench for ftdi_fifo_responder with default parameters.
//   rx_q holds bytes the host pushed (expected on adbus_out, in order);
//   tx_q holds bytes the master wrote (expected on host_rx_data, in order).
module tb_ftdi_fifo_responder;
  localparam int TXD = 2048;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ftdi_rd = 1'b1;
  logic        ftdi_wr = 1'b1;
  logic [7:0]  adbus_in = 8'h00;
  logic [7:0]  host_tx_data = 8'h00;
  logic        host_tx_valid = 1'b0;
  logic        host_rx_ready = 1'b0;
  logic        rxf, txe, adbus_oe, host_tx_ready, host_rx_valid, err_proto;
  logic [7:0]  adbus_out, host_rx_data;
  logic [10:0] rx_count;
  logic [11:0] tx_count;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  ftdi_fifo_responder dut (
    .clock(clock), .reset(reset), .ftdi_rd(ftdi_rd), .ftdi_wr(ftdi_wr),
    .adbus_in(adbus_in), .rxf(rxf), .txe(txe), .adbus_out(adbus_out),
    .adbus_oe(adbus_oe), .host_tx_data(host_tx_data),
    .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid),
    .host_rx_ready(host_rx_ready), .rx_count(rx_count), .tx_count(tx_count),
    .err_proto(err_proto), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_push(input logic [7:0] b);
    host_tx_data  = b;
    host_tx_valid = 1'b1;
    check("host_tx_ready", host_tx_ready, 1);
    tick();
    host_tx_valid = 1'b0;
    rx_q.push_back(b);
  endtask

  task automatic wait_rxf_low();
    for (int i = 0; i < 64 && rxf !== 1'b0; i++) tick();
    check("wait_rxf_low", rxf, 0);
  endtask

  // One read: RD# low 3 cycles. Fall seen 2 cycles after RD# drops,
  // flags react on the 3rd; pop lands 3 cycles after RD# rises.
  task automatic master_read();
    logic [7:0] exp;
    wait_rxf_low();
    exp = rx_q.pop_front();
    check("adbus_out_head", adbus_out, exp);
    check("rx_count_pre", rx_count, rx_q.size() + 1);
    ftdi_rd = 1'b0;
    #1;
    check("adbus_oe_rd_low", adbus_oe, 1);
    tick(); tick();
    check("rxf_detect_cycle", rxf, 0);
    tick();
    check("rxf_after_fall", rxf, 1);
    ftdi_rd = 1'b1;
    #1;
    check("adbus_oe_rd_high", adbus_oe, 0);
    tick(); tick(); tick();
    check("rx_count_post", rx_count, rx_q.size());
  endtask

  // One write: WR# low 3 cycles; tx_count moves 3 cycles after WR# drops.
  // The bus is scrambled once WR# is released to prove the early capture.
  task automatic master_write(input logic [7:0] b, input bit accept, input bit wait_txe);
    int pre;
    if (wait_txe) begin
      for (int i = 0; i < 64 && txe !== 1'b0; i++) tick();
      check("wait_txe_low", txe, 0);
    end
    pre = tx_q.size();
    check("tx_count_pre", tx_count, pre);
    adbus_in = b;
    ftdi_wr  = 1'b0;
    if (accept) tx_q.push_back(b);
    tick(); tick();
    check("tx_count_fall_cycle", tx_count, pre);
    tick();
    check("tx_count_push", tx_count, tx_q.size());
    check("txe_after_fall", txe, 1);
    ftdi_wr  = 1'b1;
    adbus_in = 8'($urandom_range(0, 255));
    tick();
  endtask

  task automatic drain_tx();
    logic [7:0] exp;
    host_rx_ready = 1'b1;
    for (int i = 0; i < TXD * 2 + 16 && tx_q.size() > 0; i++) begin
      if (host_rx_valid) begin
        exp = tx_q.pop_front();
        check("host_rx_data", host_rx_data, exp);
      end
      tick();
    end
    host_rx_ready = 1'b0;
    check("tx_scoreboard_left", tx_q.size(), 0);
    check("host_rx_valid_end", host_rx_valid, 0);
    check("tx_count_end", tx_count, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    rx_q.delete();
    tx_q.delete();
    repeat (2) tick();
  endtask

  initial begin
    int n;
    logic [7:0] exp;

    // Reset values
    repeat (3) tick();
    check("rst_rxf", rxf, 1);
    check("rst_txe", txe, 1);
    check("rst_adbus_out", adbus_out, 8'h00);
    check("rst_host_rx_valid", host_rx_valid, 0);
    check("rst_host_tx_ready", host_tx_ready, 1);
    check("rst_rx_count", rx_count, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_err", err_proto, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    tick(); tick();
    check("idle_txe_low", txe, 0);
    check("idle_rxf_high", rxf, 1);

    // 1: two host bytes read back by the master
    host_push(8'hA5);
    check("push1_rx_count", rx_count, 1);
    check("push1_rxf_still_high", rxf, 1);
    host_push(8'h3C);
    check("push2_rx_count", rx_count, 2);
    check("push2_rxf_low", rxf, 0);
    master_read();
    master_read();
    check("t1_rx_count", rx_count, 0);
    check("t1_err", err_proto, 0);
    repeat (8) tick();
    check("t1_rxf_empty", rxf, 1);

    // 2: 16 master writes, drained by the host afterwards
    for (int i = 0; i < 16; i++) master_write(8'(8'h11 + i), 1'b1, 1'b1);
    repeat (10) tick();
    check("t2_tx_count_peak", tx_count, 16);
    check("t2_host_rx_valid", host_rx_valid, 1);
    drain_tx();
    check("t2_err", err_proto, 0);

    // 3: fill TX completely, then one forced write must be dropped
    for (int i = 0; i < TXD; i++) master_write(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    repeat (12) tick();
    check("t3_txe_full", txe, 1);
    check("t3_tx_count_full", tx_count, TXD);
    check("t3_host_tx_ready", host_tx_ready, 1);
    check("t3_err_before", err_proto, 0);
    master_write(8'h77, 1'b0, 1'b0);
    repeat (8) tick();
    check("t3_err_after", err_proto, 1);
    check("t3_tx_count_kept", tx_count, TXD);
    drain_tx();

    // 4: simultaneous RD#/WR# fall: read wins, write dropped, error flagged
    do_reset();
    check("t4_err_cleared", err_proto, 0);
    host_push(8'h5A);
    wait_rxf_low();
    exp = rx_q.pop_front();
    check("t4_adbus_out", adbus_out, exp);
    adbus_in = 8'h99;
    ftdi_rd  = 1'b0;
    ftdi_wr  = 1'b0;
    repeat (3) tick();
    check("t4_state_rd_act", dbg_state, 1);
    check("t4_err", err_proto, 1);
    check("t4_rxf", rxf, 1);
    check("t4_txe", txe, 1);
    ftdi_rd = 1'b1;
    ftdi_wr = 1'b1;
    repeat (3) tick();
    check("t4_rx_count_popped", rx_count, 0);
    check("t4_tx_count_dropped", tx_count, 0);
    check("t4_host_rx_valid", host_rx_valid, 0);

    // 5: RECOVER lasts RECOVER_CYCLES (4) cycles with RXF# high, then low
    repeat (10) tick();
    host_push(8'h61);
    host_push(8'h62);
    master_read();
    n = 0;
    for (int i = 0; i < 32 && dbg_state == 2'd3; i++) begin
      check("t5_rxf_high_in_recover", rxf, 1);
      n++;
      tick();
    end
    check("t5_recover_len", n, 4);
    check("t5_rxf_low_after", rxf, 0);
    check("t5_state_idle", dbg_state, 0);
    check("t5_rx_count", rx_count, 1);
    master_read();

    // 6: reset in RD_ACT with RD# held low, then a clean read
    repeat (8) tick();
    host_push(8'hC3);
    wait_rxf_low();
    ftdi_rd = 1'b0;
    repeat (3) tick();
    check("t6_state_rd_act", dbg_state, 1);
    reset = 1'b1;
    tick();
    check("t6_rst_rx_count", rx_count, 0);
    check("t6_rst_rxf", rxf, 1);
    check("t6_rst_adbus_out", adbus_out, 8'h00);
    check("t6_rst_state", dbg_state, 0);
    tick();
    reset = 1'b0;
    rx_q.delete();
    repeat (8) tick();
    check("t6_no_fake_fall_state", dbg_state, 0);
    check("t6_no_fake_fall_err", err_proto, 0);
    check("t6_rx_count_empty", rx_count, 0);
    ftdi_rd = 1'b1;
    repeat (4) tick();
    host_push(8'hE7);
    master_read();
    check("t6_err_final", err_proto, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
